// File: rtl/sd_pkg.sv
// sd_pkg: shared FSM state, sector geometry and field widths for the sector read scheduler
package sd_pkg;
  typedef enum logic [1:0] {IDLE, ARB, READ, FLUSH} state_e;
  localparam int SECTOR_BYTES = 512;
  localparam int ADDR_W = $clog2(SECTOR_BYTES);
  localparam int SECTOR_W = 32;
  localparam int COUNT_W = 16;
endpackage

// File: rtl/sd_sector_read_scheduler_if.sv
// sd_sector_read_scheduler_if: requester command handshake and byte delivery bus
interface sd_sector_read_scheduler_if
  import sd_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0] cmd_valid;
  logic [NREQ-1:0] cmd_ready;
  logic [NREQ-1:0][SECTOR_W-1:0] cmd_sector;
  logic [NREQ-1:0][COUNT_W-1:0] cmd_count;
  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] cmd_done;
  logic out_valid;
  logic [IDW-1:0] out_id;
  logic [SECTOR_W-1:0] out_sector;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0] out_data;
  modport master (
    output cmd_valid, cmd_sector, cmd_count,
    input cmd_ready, busy, cmd_done, out_valid, out_id, out_sector, out_addr, out_data
  );
  modport slave (
    input cmd_valid, cmd_sector, cmd_count,
    output cmd_ready, busy, cmd_done, out_valid, out_id, out_sector, out_addr, out_data
  );
endinterface

// File: rtl/sd_sector_read_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first requester after the last grant, wrapping around
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  gnt,
  output logic            any
);
  // scan farthest-to-nearest so the nearest requester after last wins
  always_comb begin
    gnt = last;
    any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        gnt = IDW'((int'(last) + k) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sd_sector_read_scheduler.sv
// sd_sector_read_scheduler: shares one sector reader among requesters, one sector per grant
module sd_sector_read_scheduler
  import sd_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_sector_read_scheduler_if.slave bus,
  output logic                 rd_start,
  output logic [SECTOR_W-1:0]  rd_sector,
  input  logic                 rd_done,
  input  logic                 rd_valid,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [7:0]           rd_data
);
  state_e state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d, arb_gnt;
  logic arb_any;
  logic [NREQ-1:0] busy_q, busy_d, zero_done_q, zero_done_d, flush_done;
  logic [NREQ-1:0][SECTOR_W-1:0] sector_q, sector_d;
  logic [NREQ-1:0][COUNT_W-1:0] count_q, count_d;
  logic out_valid_q, out_valid_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [SECTOR_W-1:0] out_sector_q, out_sector_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [7:0] out_data_q, out_data_d;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(busy_q), .last(last_grant_q), .gnt(arb_gnt), .any(arb_any)
  );

  assign rd_start = state_q == READ;
  assign rd_sector = rd_start ? sector_q[last_grant_q] : '0;
  assign bus.cmd_ready = ~busy_q;
  assign bus.busy = busy_q;
  assign bus.cmd_done = zero_done_q | flush_done;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id = out_id_q;
  assign bus.out_sector = out_sector_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;

  // command acceptance, arbitration FSM, slot bookkeeping and byte forwarding
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    busy_d = busy_q;
    sector_d = sector_q;
    count_d = count_q;
    zero_done_d = '0;
    flush_done = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.cmd_valid[i] && !busy_q[i]) begin
        sector_d[i] = bus.cmd_sector[i];
        count_d[i] = bus.cmd_count[i];
        busy_d[i] = bus.cmd_count[i] != '0;
        zero_done_d[i] = bus.cmd_count[i] == '0;
      end
    end
    case (state_q)
      IDLE: state_d = |busy_q ? ARB : IDLE;
      ARB: begin
        state_d = arb_any ? READ : IDLE;
        last_grant_d = arb_any ? arb_gnt : last_grant_q;
      end
      READ: if (rd_done) begin
        sector_d[last_grant_q] = sector_q[last_grant_q] + 1'b1;
        count_d[last_grant_q] = count_q[last_grant_q] - 1'b1;
        state_d = FLUSH;
      end
      FLUSH: begin
        if (count_q[last_grant_q] == '0) begin
          flush_done[last_grant_q] = 1'b1;
          busy_d[last_grant_q] = 1'b0;
        end
        state_d = |busy_d ? ARB : IDLE;
      end
    endcase
    out_valid_d = rd_start && rd_valid;
    out_id_d = last_grant_q;
    out_sector_d = sector_q[last_grant_q];
    out_addr_d = rd_addr;
    out_data_d = rd_data;
  end

  // state and slot registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      busy_q <= '0;
      zero_done_q <= '0;
      sector_q <= '0;
      count_q <= '0;
      out_valid_q <= 1'b0;
      out_id_q <= '0;
      out_sector_q <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      busy_q <= busy_d;
      zero_done_q <= zero_done_d;
      sector_q <= sector_d;
      count_q <= count_d;
      out_valid_q <= out_valid_d;
      out_id_q <= out_id_d;
      out_sector_q <= out_sector_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_sd_sector_read_scheduler.sv
// tb_sd_sector_read_scheduler: directed checks of arbitration, byte delivery, completion and reset
module tb_sd_sector_read_scheduler;
  logic clk, rst_n, rd_start, rd_done, rd_valid, spur;
  logic [31:0] rd_sector, sec;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  int checks = 0, failures = 0;
  int byte_cnt[2], done_cnt[2], done_bytes[2];
  int total_ov = 0, data_err = 0;
  logic prev_start = 1'b0;
  logic [31:0] seq[$];
  int b, b0, b1, d0, d1, ov;
  logic ok;

  sd_sector_read_scheduler_if #(.NREQ(2)) bus ();

  sd_sector_read_scheduler #(.NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rd_start(rd_start), .rd_sector(rd_sector), .rd_done(rd_done),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sector reader model: 512 bytes then a done pulse; data derived from the sector number
  initial begin
    rd_valid = 0; rd_done = 0; rd_addr = 0; rd_data = 0; sec = 0;
    forever begin
      @(negedge clk);
      if (rd_start && rst_n) begin
        sec = rd_sector;
        for (int a = 0; a < 512; a++) begin
          if (!rst_n) break;
          rd_valid = 1; rd_addr = 9'(a); rd_data = sec[7:0] ^ 8'(a) ^ 8'h5A;
          @(negedge clk);
        end
        rd_valid = 0;
        if (rst_n) begin
          rd_done = 1;
          @(negedge clk);
          rd_done = 0;
        end
      end else begin
        rd_valid = spur; rd_done = spur; rd_addr = 9'd3; rd_data = 8'hEE;
      end
    end
  end

  // monitor: sector issue order, per-owner byte counts, payload integrity, completion pulses
  always @(negedge clk) begin
    if (rd_start && !prev_start) seq.push_back(rd_sector);
    if (bus.out_valid) begin
      byte_cnt[bus.out_id]++;
      total_ov++;
      if (bus.out_data !== (bus.out_sector[7:0] ^ bus.out_addr[7:0] ^ 8'h5A)) data_err++;
    end
    for (int i = 0; i < 2; i++)
      if (bus.cmd_done[i]) begin
        done_cnt[i]++;
        done_bytes[i] = byte_cnt[i];
      end
    prev_start = rd_start;
  end

  task automatic issue(input logic [1:0] v, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [15:0] c0, input logic [15:0] c1);
    bus.cmd_sector[0] = s0; bus.cmd_sector[1] = s1;
    bus.cmd_count[0] = c0; bus.cmd_count[1] = c1;
    bus.cmd_valid = v;
    @(negedge clk);
    bus.cmd_valid = '0;
  endtask

  task automatic wait_idle(input string tag);
    ok = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (bus.busy == 2'b00 && !rd_start) begin ok = 1; break; end
    end
    chk({tag, "_timeout"}, ok, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic snap();
    b = seq.size(); b0 = byte_cnt[0]; b1 = byte_cnt[1];
    d0 = done_cnt[0]; d1 = done_cnt[1]; ov = total_ov;
  endtask

  initial begin
    rst_n = 0; spur = 0;
    bus.cmd_valid = '0; bus.cmd_sector = '0; bus.cmd_count = '0;
    byte_cnt = '{0, 0}; done_cnt = '{0, 0}; done_bytes = '{0, 0};
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cmd_ready, 2'b11);
    chk("rst_done", bus.cmd_done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rd_start", rd_start, 0);
    chk("rst_rd_sector", rd_sector, 0);
    chk("rst_out_fields", {bus.out_id, bus.out_sector, bus.out_addr, bus.out_data}, 0);
    rst_n = 1;
    @(negedge clk);

    snap();
    issue(2'b11, 32'd10, 32'd50, 16'd2, 16'd2);
    chk("dual_busy", bus.busy, 2'b11);
    chk("dual_ready", bus.cmd_ready, 2'b00);
    wait_idle("dual");
    chk("dual_seq0", seq[b], 10);
    chk("dual_seq1", seq[b+1], 50);
    chk("dual_seq2", seq[b+2], 11);
    chk("dual_seq3", seq[b+3], 51);
    chk("dual_nseq", seq.size() - b, 4);
    chk("dual_done0", done_cnt[0] - d0, 1);
    chk("dual_done1", done_cnt[1] - d1, 1);
    chk("dual_bytes0_at_done", done_bytes[0] - b0, 1024);
    chk("dual_bytes1_at_done", done_bytes[1] - b1, 1024);

    snap();
    issue(2'b01, 32'd100, 32'd0, 16'd3, 16'd0);
    chk("r0_busy", bus.busy, 2'b01);
    wait_idle("r0");
    chk("r0_seq0", seq[b], 100);
    chk("r0_seq1", seq[b+1], 101);
    chk("r0_seq2", seq[b+2], 102);
    chk("r0_nseq", seq.size() - b, 3);
    chk("r0_bytes", byte_cnt[0] - b0, 1536);
    chk("r0_bytes_r1", byte_cnt[1] - b1, 0);
    chk("r0_done", done_cnt[0] - d0, 1);
    chk("r0_bytes_at_done", done_bytes[0] - b0, 1536);

    snap();
    issue(2'b10, 32'd0, 32'd77, 16'd0, 16'd0);
    chk("zero_done_pulse", bus.cmd_done, 2'b10);
    chk("zero_busy", bus.busy, 0);
    chk("zero_rd_start", rd_start, 0);
    @(negedge clk);
    chk("zero_done_clear", bus.cmd_done, 0);
    repeat (3) @(negedge clk);
    chk("zero_no_read", seq.size() - b, 0);
    chk("zero_rd_start_later", rd_start, 0);
    chk("zero_done_count", done_cnt[1] - d1, 1);

    snap();
    issue(2'b01, 32'hFFFF_FFFF, 32'd0, 16'd2, 16'd0);
    wait_idle("wrap");
    chk("wrap_seq0", seq[b], 32'hFFFF_FFFF);
    chk("wrap_seq1", seq[b+1], 32'h0000_0000);
    chk("wrap_done", done_cnt[0] - d0, 1);

    snap();
    spur = 1;
    repeat (4) @(negedge clk);
    spur = 0;
    repeat (3) @(negedge clk);
    chk("spur_out_valid", total_ov - ov, 0);
    chk("spur_rd_start", rd_start, 0);
    chk("spur_no_read", seq.size() - b, 0);
    chk("spur_done", bus.cmd_done, 0);

    snap();
    issue(2'b01, 32'd7, 32'd0, 16'd2, 16'd0);
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (byte_cnt[0] - b0 >= 200) begin ok = 1; break; end
    end
    chk("mid_reach_byte200", ok, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.cmd_done, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_rd_start", rd_start, 0);
    chk("mid_rst_rd_sector", rd_sector, 0);
    chk("mid_rst_out_fields", {bus.out_id, bus.out_sector, bus.out_addr, bus.out_data}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("mid_no_done", done_cnt[0] - d0, 0);
    snap();
    issue(2'b10, 32'd0, 32'd300, 16'd0, 16'd1);
    wait_idle("after_rst");
    chk("after_rst_seq", seq[b], 300);
    chk("after_rst_done", done_cnt[1] - d1, 1);
    chk("after_rst_bytes", done_bytes[1] - b1, 512);
    chk("data_integrity", data_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
